// File: rtl/pla_grant_scheduler.sv
// Round-robin owner of the 4-way PLA select pair, with hold limit and a one-cycle break-before-make gap.
// Optional macro SCHED_LOCK_EN adds a lock input that freezes the hold counter while owning.
module pla_grant_scheduler #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
`ifdef SCHED_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             hold_frozen;
  logic             hold_expired;

`ifdef SCHED_LOCK_EN
  assign hold_frozen = lock;
`else
  assign hold_frozen = 1'b0;
`endif

  assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX));

  // First set request at or after ptr, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = 4'b0001 << win;
          sel_d   = ~win;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          owner_d = win;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!req[owner_q] || (hold_expired && !hold_frozen)) begin
          // sel keeps the last owner's code; downstream gates on busy.
          grant_d   = 4'b0000;
          busy_d    = 1'b0;
          ptr_d     = owner_q + 2'd1;
          timeout_d = req[owner_q];
          state_d   = GAP;
        end else if (!hold_frozen) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      cnt_q     <= '0;
      grant_q   <= 4'b0000;
      sel_q     <= 2'b00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pla_grant_scheduler.sv
// Directed bench for pla_grant_scheduler: reset, single request, rotation, timeouts, mid-owner reset.
module tb_pla_grant_scheduler;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;
  logic [1:0] state_dbg;
`ifdef SCHED_LOCK_EN
  logic       lock;
`endif

  int checks;
  int errors;
  logic [3:0] exp_q[$];
  logic [3:0] exp_g;

  pla_grant_scheduler #(.HOLD_MAX(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
`ifdef SCHED_LOCK_EN
    .lock      (lock),
`endif
    .sel       (sel),
    .grant     (grant),
    .busy      (busy),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one active edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic t, input logic [1:0] st);
    check({tag, "/grant"}, grant, g);
    check({tag, "/sel"}, {2'b00, sel}, {2'b00, s});
    check({tag, "/busy"}, {3'b000, busy}, {3'b000, b});
    check({tag, "/timeout"}, {3'b000, timeout}, {3'b000, t});
    check({tag, "/state"}, {2'b00, state_dbg}, {2'b00, st});
  endtask

  // Full timeout cycle for a continuously held requester: 8 owned cycles, pulse, gap.
  task automatic hold_to_timeout(input string tag, input logic [3:0] g, input logic [1:0] s);
    step();
    check_out({tag, "_grant"}, g, s, 1'b1, 1'b0, S_OWN);
    for (int k = 0; k < 7; k++) begin
      step();
      check_out({tag, "_held"}, g, s, 1'b1, 1'b0, S_OWN);
    end
    step();
    check_out({tag, "_timeout"}, 4'b0000, s, 1'b0, 1'b1, S_GAP);
    step();
    check_out({tag, "_after_gap"}, 4'b0000, s, 1'b0, 1'b0, S_IDLE);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b1111;
`ifdef SCHED_LOCK_EN
    lock   = 1'b0;
`endif

    // Reset held with all requests raised
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("reset", 4'b0000, 2'b00, 1'b0, 1'b0, S_IDLE);
    end
    rst_n = 1'b1;
    req   = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("idle_noreq", 4'b0000, 2'b00, 1'b0, 1'b0, S_IDLE);
    end

    // Single request from requester 2
    req = 4'b0100;
    step();
    check_out("single_grant", 4'b0100, 2'b01, 1'b1, 1'b0, S_OWN);
    step();
    step();
    check_out("single_held", 4'b0100, 2'b01, 1'b1, 1'b0, S_OWN);
    req = 4'b0000;
    step();
    check_out("single_release", 4'b0000, 2'b01, 1'b0, 1'b0, S_GAP);
    step();
    check_out("single_idle", 4'b0000, 2'b01, 1'b0, 1'b0, S_IDLE);

    // Reset to bring the pointer back to requester 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Rotation with all requesters active; each owner drops after 2 cycles
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    req = 4'b1111;
    while (exp_q.size() > 0) begin
      exp_g = exp_q.pop_front();
      step();
      check_out("rot_grant", exp_g, ~{exp_g[3] | exp_g[2], exp_g[3] | exp_g[1]}, 1'b1, 1'b0, S_OWN);
      step();
      check_out("rot_held", exp_g, ~{exp_g[3] | exp_g[2], exp_g[3] | exp_g[1]}, 1'b1, 1'b0, S_OWN);
      req = 4'b1111 & ~exp_g;
      step();
      check_out("rot_gap", 4'b0000, ~{exp_g[3] | exp_g[2], exp_g[3] | exp_g[1]}, 1'b0, 1'b0, S_GAP);
      req = 4'b1111;
      step();
      check_out("rot_idle", 4'b0000, ~{exp_g[3] | exp_g[2], exp_g[3] | exp_g[1]}, 1'b0, 1'b0, S_IDLE);
    end
    req = 4'b0000;
    step();
    check_out("rot_quiet", 4'b0000, 2'b11, 1'b0, 1'b0, S_IDLE);

    // Timeout with a single requester: re-granted after the gap
    req = 4'b0010;
    hold_to_timeout("to_single", 4'b0010, 2'b10);
    step();
    check_out("to_regrant", 4'b0010, 2'b10, 1'b1, 1'b0, S_OWN);
    req = 4'b0000;
    step();
    check_out("to_drop", 4'b0000, 2'b10, 1'b0, 1'b0, S_GAP);
    step();

    // Timeout with contention: 0 -> 1 -> 0 (pointer starts at 2)
    req = 4'b0011;
    hold_to_timeout("to_c0", 4'b0001, 2'b11);
    hold_to_timeout("to_c1", 4'b0010, 2'b10);
    step();
    check_out("to_c0_again", 4'b0001, 2'b11, 1'b1, 1'b0, S_OWN);

    // Reset in the middle of requester 3's ownership
    req = 4'b1000;
    step();
    check_out("mid_drop0", 4'b0000, 2'b11, 1'b0, 1'b0, S_GAP);
    step();
    step();
    check_out("mid_own3", 4'b1000, 2'b00, 1'b1, 1'b0, S_OWN);
    req   = 4'b1111;
    rst_n = 1'b0;
    step();
    check_out("mid_reset", 4'b0000, 2'b00, 1'b0, 1'b0, S_IDLE);
    rst_n = 1'b1;
    step();
    check_out("post_reset", 4'b0001, 2'b11, 1'b1, 1'b0, S_OWN);

    // Owner drops on the same edge the hold limit is reached: no timeout
    for (int k = 0; k < 7; k++) begin
      step();
    end
    check_out("limit_held", 4'b0001, 2'b11, 1'b1, 1'b0, S_OWN);
    req = 4'b0000;
    step();
    check_out("limit_drop", 4'b0000, 2'b11, 1'b0, 1'b0, S_GAP);
    step();
    check_out("limit_idle", 4'b0000, 2'b11, 1'b0, 1'b0, S_IDLE);

`ifdef SCHED_LOCK_EN
    // Locked owner outlives the hold limit and still releases on req drop
    req  = 4'b0001;
    lock = 1'b1;
    step();
    check_out("lock_grant", 4'b0001, 2'b11, 1'b1, 1'b0, S_OWN);
    for (int k = 0; k < 20; k++) begin
      step();
      check_out("lock_held", 4'b0001, 2'b11, 1'b1, 1'b0, S_OWN);
    end
    req = 4'b0000;
    step();
    check_out("lock_drop", 4'b0000, 2'b11, 1'b0, 1'b0, S_GAP);
    lock = 1'b0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pla_grant_scheduler.md
Name: pla_grant_scheduler

Overview:
- Round-robin scheduler that shares the 4-way decoded PLA select resource between 4 requesters.
- Arbitrates on req[3:0], registers the winner, drives the 2-bit PLA select pair sel[1:0] = {A,B} and a matching one-hot grant.
- Enforces a maximum hold time and a one-cycle break-before-make gap between owners.
- Sits between requesting agents and the decoder PLA; the PLA outputs F1..F4 track grant[0..3].

Parameters:
- HOLD_MAX, 8, maximum consecutive cycles one requester may own the grant (legal range 2..2^CNT_W-1).
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  4  request per requester; level-held while ownership is wanted.
- sel  output  2  PLA select {A,B}: requester 0 -> 2'b11 (F1), 1 -> 2'b10 (F2), 2 -> 2'b01 (F3), 3 -> 2'b00 (F4); i.e. sel = ~idx.
- grant  output  4  one-hot registered grant, all zero when no owner.
- busy  output  1  high while in OWN.
- timeout  output  1  one-cycle pulse when an owner is forcibly released.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, grant=4'b0000, sel=2'b00, busy=0, timeout=0.
  - ptr=0 (search starts at requester 0), hold counter=0.
- All outputs are registered; no combinational path from req to outputs.
- sel is don't-care-free: it holds the last owner's code when grant=0. The PLA output is gated downstream by busy.
- States: IDLE, OWN, GAP.
- IDLE:
  - If any req bit is set at edge n, the winner is the first set bit searching ptr, ptr+1, ... mod 4.
  - After edge n: grant=onehot(winner), sel=~winner, busy=1, cnt=1, state=OWN.
  - Latency is 1 cycle from sampled req to grant.
- OWN:
  - If req[owner]=0 at an edge: grant=0, busy=0, ptr=owner+1 mod 4, state=GAP.
  - Else if cnt==HOLD_MAX: grant=0, busy=0, timeout=1 for one cycle, ptr=owner+1 mod 4, state=GAP.
  - Else cnt increments; grant is unchanged.
  - Other req bits are ignored while in OWN.
- GAP:
  - Exactly one cycle with grant=0, then state=IDLE.
  - Arbitration resumes at the following edge, so a back-to-back handover costs 2 idle cycles: OWN->GAP->IDLE->OWN.
- Boundaries:
  - Owner dropping req on the same edge that cnt==HOLD_MAX is a normal release: timeout stays 0.
  - ptr wraps 3 -> 0.
  - A timed-out requester still holding req is served again only after the other active requesters, per the RR order.
  - req=4'b0000 in IDLE holds IDLE indefinitely.
  - Reset mid-OWN drops grant on the reset edge and returns ptr to 0.
- Invariants:
  - grant is always zero or one-hot.
  - grant!=0 implies busy=1 and sel==~index(grant).

Optional Feature:
- Macro SCHED_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - While in OWN with lock=1, cnt does not advance and the timeout cannot fire.
  - Release by req drop still works.
  - lock is ignored in IDLE and GAP.
- When undefined:
  - No lock port.
  - Hold time is always bounded by HOLD_MAX.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 edges with req=4'b1111 -> grant=0000, busy=0, timeout=0 throughout. Release reset with req=0000 -> stays IDLE, grant=0000.
- Single request: req=4'b0100 at edge n -> grant=0100, sel=2'b01, busy=1 after edge n. Drop req at edge n+3 -> grant=0000 after n+3, one GAP cycle, back to IDLE.
- Rotation: req=4'b1111 held, each owner drops its req after 2 cycles then re-raises it -> grant order 0001, 0010, 0100, 1000, 0001 with sel 11, 10, 01, 00, 11, 2-cycle gap between each.
- Timeout: HOLD_MAX=8, req=4'b0010 held continuously -> grant=0010 for exactly 8 cycles, timeout pulses once, GAP, then re-granted 0010 since it is the only requester.
- Timeout with contention: req=4'b0011 held -> 0001 for 8 cycles, timeout, then 0010 for 8 cycles, timeout, then 0001.
- Mid-operation reset and lock: reset during OWN of requester 3 -> grant=0000 on that edge, next grant with req=1111 is 0001. With SCHED_LOCK_EN defined, lock=1 and req=0001 held 20 cycles -> grant stays 0001 and no timeout.
